// File: rtl/spi_peripheral_rxfifo.sv
// SPI peripheral: synchronised SCLK/COPI/CS, runtime SPI mode, TX holding
// register feeding CIPO, and a first-word-fall-through RX FIFO with sticky
// overflow/timeout status.
module spi_peripheral_rxfifo #(
   parameter int DATA_W         = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int MSB_FIRST      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCLK,
   input  logic              COPI,
   input  logic              spi_cs_n,
   output logic              CIPO,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              rx_enable,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic [15:0]       frame_count,
   output logic              overflow,
   output logic              timeout,
   input  logic              clr_status,
   output logic              busy
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ABORT} state_t;

   state_t              r_state;
   logic                r_sclk_s1, r_sclk_s2, r_sclk_s3;
   logic                r_copi_s1, r_copi_s2;
   logic                r_cs_s1, r_cs_s2, r_cs_s3;
   logic                r_cpol, r_cpha;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic [31:0]         r_to_cnt;
   logic [DATA_W-1:0]   r_rx_shift;
   logic [DATA_W-1:0]   r_tx_shift;
   logic [DATA_W-1:0]   r_tx_hold;
   logic                r_cipo;
   logic [15:0]         r_frame_cnt;
   logic                r_overflow, r_timeout;
   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]      r_count;

   logic                w_sclk_rise, w_sclk_fall, w_lead, w_trail;
   logic                w_sample, w_shift, w_cs_low, w_start;
   logic [DATA_W-1:0]   w_rx_next, w_tx_adv, w_hold_adv;
   logic                w_tx_bit, w_hold_bit;
   logic                w_full, w_pop, w_push_ok, w_push;

   // Two-stage synchronisers plus an edge-history stage; CS idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_s3 <= 1'b0;
         r_copi_s1 <= 1'b0; r_copi_s2 <= 1'b0;
         r_cs_s1   <= 1'b1; r_cs_s2   <= 1'b1; r_cs_s3   <= 1'b1;
      end else begin
         r_sclk_s1 <= SCLK;     r_sclk_s2 <= r_sclk_s1; r_sclk_s3 <= r_sclk_s2;
         r_copi_s1 <= COPI;     r_copi_s2 <= r_copi_s1;
         r_cs_s1   <= spi_cs_n; r_cs_s2   <= r_cs_s1;   r_cs_s3   <= r_cs_s2;
      end
   end

   assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
   assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
   assign w_lead      = r_cpol ? w_sclk_fall : w_sclk_rise;
   assign w_trail     = r_cpol ? w_sclk_rise : w_sclk_fall;
   assign w_sample    = r_cpha ? w_trail : w_lead;
   assign w_shift     = r_cpha ? w_lead : w_trail;
   assign w_cs_low    = ~r_cs_s2;
   // CS must read low on two consecutive synced samples before a frame opens.
   assign w_start     = ~r_cs_s2 & ~r_cs_s3 & rx_enable;

   assign w_rx_next  = (MSB_FIRST != 0) ? {r_rx_shift[DATA_W-2:0], r_copi_s2}
                                        : {r_copi_s2, r_rx_shift[DATA_W-1:1]};
   assign w_tx_bit   = (MSB_FIRST != 0) ? r_tx_shift[DATA_W-1] : r_tx_shift[0];
   assign w_tx_adv   = (MSB_FIRST != 0) ? {r_tx_shift[DATA_W-2:0], 1'b0}
                                        : {1'b0, r_tx_shift[DATA_W-1:1]};
   assign w_hold_bit = (MSB_FIRST != 0) ? r_tx_hold[DATA_W-1] : r_tx_hold[0];
   assign w_hold_adv = (MSB_FIRST != 0) ? {r_tx_hold[DATA_W-2:0], 1'b0}
                                        : {1'b0, r_tx_hold[DATA_W-1:1]};

   assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
   assign w_pop     = rx_valid & rx_ready;
   assign w_push_ok = ~w_full | w_pop;
   assign w_push    = (r_state == COMMIT) & w_push_ok;

   // Frame FSM: shifting, word commit, timeout abort, status flags, TX hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cpol      <= 1'b0;
         r_cpha      <= 1'b0;
         r_bit_cnt   <= '0;
         r_to_cnt    <= '0;
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         r_tx_hold   <= '0;
         r_cipo      <= 1'b0;
         r_frame_cnt <= '0;
         r_overflow  <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         // Clear first so a setting event later in this block wins.
         if (clr_status) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               r_cipo <= 1'b0;
               if (w_start) begin
                  r_state     <= SHIFT;
                  r_cpol      <= cpol;
                  r_cpha      <= cpha;
                  r_bit_cnt   <= '0;
                  r_to_cnt    <= '0;
                  r_frame_cnt <= '0;
                  // Mode with cpha=0 presents the first bit before any edge.
                  r_cipo      <= w_hold_bit;
                  r_tx_shift  <= cpha ? r_tx_hold : w_hold_adv;
                  r_tx_hold   <= '0;
               end
            end
            SHIFT: begin
               if (!w_cs_low) begin
                  r_state   <= IDLE;
                  r_bit_cnt <= '0;
                  r_to_cnt  <= '0;
                  r_cipo    <= 1'b0;
               end else begin
                  if (w_sample) begin
                     r_rx_shift <= w_rx_next;
                     r_to_cnt   <= '0;
                     if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                        r_state   <= COMMIT;
                        r_bit_cnt <= '0;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     end
                  end else if (r_bit_cnt != '0) begin
                     if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= ABORT;
                        r_timeout <= 1'b1;
                        r_bit_cnt <= '0;
                        r_to_cnt  <= '0;
                     end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                     end
                  end else begin
                     r_to_cnt <= '0;
                  end
                  if (w_shift) begin
                     r_cipo     <= w_tx_bit;
                     r_tx_shift <= w_tx_adv;
                  end
               end
            end
            COMMIT: begin
               if (!w_push_ok) r_overflow <= 1'b1;
               if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
               r_tx_shift <= r_tx_hold;
               r_tx_hold  <= '0;
               r_bit_cnt  <= '0;
               r_to_cnt   <= '0;
               r_state    <= w_cs_low ? SHIFT : IDLE;
            end
            default: begin
               r_cipo <= 1'b0;
               if (!w_cs_low) r_state <= IDLE;
            end
         endcase
         // A host write lands after any transfer out of the holding register.
         if (tx_load) r_tx_hold <= tx_data;
      end
   end

   // FIFO pointers and occupancy; a pop and push together keep the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (PTR_W+1)'(1);
      end
   end

   // FIFO storage; the head is read combinationally for fall-through.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_rx_shift;
   end

   assign rx_valid    = (r_count != '0);
   assign rx_data     = rx_valid ? r_mem[r_rd_ptr] : '0;
   assign CIPO        = r_cipo & w_cs_low & ((r_state == SHIFT) | (r_state == COMMIT));
   assign frame_count = r_frame_cnt;
   assign overflow    = r_overflow;
   assign timeout     = r_timeout;
   assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_spi_peripheral_rxfifo.sv
// Randomised SPI-controller bench with a queue scoreboard for RX words.
`timescale 1ns/1ps
module tb_spi_peripheral_rxfifo;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int TO_CYC = 200;
   localparam int HALF   = 6;

   logic clk = 1'b0, rst = 1'b1;
   logic SCLK = 1'b0, COPI = 1'b0, spi_cs_n = 1'b1;
   logic cpol = 1'b0, cpha = 1'b0, rx_enable = 1'b1;
   logic tx_load = 1'b0, rx_ready = 1'b0, clr_status = 1'b0;
   logic [7:0] tx_data = '0;
   logic CIPO, rx_valid, overflow, timeout, busy;
   logic [7:0] rx_data;
   logic [15:0] frame_count;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   bit   m_cpol, m_cpha;
   bit   exp_ovf;
   int   exp_fc;
   logic [7:0] cap;
   logic [7:0] txs[4];
   logic [7:0] wrd;

   always #5 clk = ~clk;

   spi_peripheral_rxfifo #(
      .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC), .MSB_FIRST(1)
   ) dut (
      .clk(clk), .rst(rst), .SCLK(SCLK), .COPI(COPI), .spi_cs_n(spi_cs_n),
      .CIPO(CIPO), .cpol(cpol), .cpha(cpha), .rx_enable(rx_enable),
      .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_count(frame_count),
      .overflow(overflow), .timeout(timeout), .clr_status(clr_status),
      .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted pop is checked against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && rx_valid && rx_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_unexpected: got %02h required no word", rx_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check("rx_word", rx_data, mon_exp);
            $display("pop word %02h expected %02h", rx_data, mon_exp);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Half SCLK period; optional pop exactly in the commit cycle, optional latency check.
   task automatic wait_half(input bit pop, input bit lat);
      for (int k = 1; k <= HALF; k++) begin
         @(posedge clk);
         #1;
         if (lat && k == 3) check("lat_commit_cycle_valid", rx_valid, 0);
         if (lat && k == 4) check("lat_t2_valid", rx_valid, 1);
         if (pop && k == 3) rx_ready = 1'b1;
         if (pop && k == 4) rx_ready = 1'b0;
      end
   endtask

   // Reference model: FIFO of DEPTH words, drop and flag when full unless popped.
   task automatic push_expect(input logic [7:0] w, input bit pop);
      if (exp_q.size() < DEPTH || pop) exp_q.push_back(w);
      else exp_ovf = 1'b1;
      if (exp_fc < 16'hFFFF) exp_fc++;
   endtask

   task automatic load_tx(input logic [7:0] v);
      tx_data = v;
      tx_load = 1'b1;
      cycles(1);
      tx_load = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] word, input int nbits, input bit pop,
                            input bit lat, input bit do_load, input logic [7:0] nxt,
                            output logic [7:0] c);
      c = '0;
      for (int i = 0; i < nbits; i++) begin
         bit last;
         last = (i == nbits - 1) && (nbits == DATA_W);
         if (!m_cpha) begin
            COPI = word[7-i];
            wait_half(1'b0, 1'b0);
            c = {c[6:0], CIPO};
            SCLK = ~m_cpol;
            if (last) push_expect(word, pop);
            wait_half(last && pop, last && lat);
            SCLK = m_cpol;
         end else begin
            wait_half(1'b0, 1'b0);
            SCLK = ~m_cpol;
            COPI = word[7-i];
            wait_half(1'b0, 1'b0);
            c = {c[6:0], CIPO};
            SCLK = m_cpol;
            if (last) begin
               push_expect(word, pop);
               wait_half(pop, lat);
            end
         end
         if (i == 0 && do_load) load_tx(nxt);
      end
   endtask

   task automatic start_frame(input bit pol, input bit pha, input bit do_load, input logic [7:0] v);
      m_cpol = pol; m_cpha = pha;
      cpol = pol; cpha = pha;
      SCLK = pol;
      cycles(4);
      if (do_load) load_tx(v);
      spi_cs_n = 1'b0;
      exp_fc = 0;
      cycles(2 * HALF);
   endtask

   task automatic end_frame();
      wait_half(1'b0, 1'b0);
      spi_cs_n = 1'b1;
      cycles(2 * HALF);
      check("end_busy", busy, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      rx_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         cycles(1);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d words left required 0", exp_q.size());
         exp_q.delete();
      end
      cycles(2);
      check("drain_empty", rx_valid, 0);
   endtask

   initial begin
      #3_000_000;
      n_err++;
      $display("FAIL watchdog: got no finish required finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      exp_ovf = 1'b0;
      exp_fc  = 0;
      cycles(5);
      rst = 1'b0;
      cycles(1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_cipo", CIPO, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_timeout", timeout, 0);
      check("rst_busy", busy, 0);

      // Mode 0 single word with latency check.
      rx_ready = 1'b0;
      start_frame(1'b0, 1'b0, 1'b0, 8'h00);
      check("start_busy", busy, 1);
      send_word(8'hA5, 8, 1'b0, 1'b1, 1'b0, 8'h00, cap);
      check("a5_frame_count", frame_count, exp_fc);
      check("a5_head", rx_data, 8'hA5);
      end_frame();
      check("a5_fc_hold_idle", frame_count, exp_fc);
      drain();

      // All four modes with TX data.
      for (int m = 0; m < 4; m++) begin
         start_frame(m[1], m[0], 1'b1, 8'hC3);
         send_word(8'h3C, 8, 1'b0, 1'b0, 1'b0, 8'h00, cap);
         check($sformatf("mode%0d_cipo", m), cap, 8'hC3);
         check($sformatf("mode%0d_fc", m), frame_count, exp_fc);
         end_frame();
         check("idle_cipo", CIPO, 0);
         drain();
      end

      // Overflow with a stalled consumer, then pop coinciding with commit.
      rx_ready = 1'b0;
      exp_ovf = 1'b0;
      start_frame(1'b0, 1'b0, 1'b0, 8'h00);
      for (int w = 0; w < 5; w++) begin
         wrd = 8'($urandom_range(255, 0));
         send_word(wrd, 8, 1'b0, 1'b0, 1'b0, 8'h00, cap);
         check("ovf_cipo_cleared_hold", cap, 0);
      end
      check("ovf_flag", overflow, exp_ovf);
      check("ovf_fc", frame_count, exp_fc);
      clr_status = 1'b1;
      cycles(1);
      clr_status = 1'b0;
      check("ovf_cleared", overflow, 0);
      wrd = 8'($urandom_range(255, 0));
      send_word(wrd, 8, 1'b1, 1'b0, 1'b0, 8'h00, cap);
      check("full_pop_push_ovf", overflow, 0);
      check("full_pop_push_valid", rx_valid, 1);
      end_frame();
      drain();

      // CS rises after 5 bits: partial word discarded.
      start_frame(1'b0, 1'b0, 1'b0, 8'h00);
      send_word(8'h5A, 8, 1'b0, 1'b0, 1'b0, 8'h00, cap);
      send_word(8'hFF, 5, 1'b0, 1'b0, 1'b0, 8'h00, cap);
      end_frame();
      check("partial_fc", frame_count, exp_fc);
      drain();

      // Idle gap never times out; stall after 3 bits does.
      rx_ready = 1'b0;
      start_frame(1'b0, 1'b0, 1'b0, 8'h00);
      cycles(TO_CYC + 100);
      check("gap_no_timeout", timeout, 0);
      check("gap_busy", busy, 1);
      send_word(8'hE7, 3, 1'b0, 1'b0, 1'b0, 8'h00, cap);
      cycles(TO_CYC - 60);
      check("stall_before_limit", timeout, 0);
      cycles(100);
      check("stall_timeout", timeout, 1);
      check("abort_busy", busy, 1);
      check("abort_cipo", CIPO, 0);
      for (int e = 0; e < 8; e++) begin
         SCLK = ~SCLK;
         cycles(HALF);
      end
      check("abort_ignores_sclk", busy, 1);
      check("abort_no_push", rx_valid, 0);
      SCLK = 1'b0;
      end_frame();
      check("abort_fc", frame_count, 0);
      clr_status = 1'b1;
      cycles(1);
      clr_status = 1'b0;
      check("timeout_cleared", timeout, 0);

      // Randomised frames: random mode, word count, RX and TX data.
      for (int f = 0; f < 10; f++) begin
         int nw;
         int md;
         nw = $urandom_range(4, 1);
         md = $urandom_range(3, 0);
         for (int k = 0; k < 4; k++) txs[k] = 8'($urandom_range(255, 0));
         rx_ready = 1'b1;
         start_frame(md[1], md[0], 1'b1, txs[0]);
         for (int k = 0; k < nw; k++) begin
            wrd = 8'($urandom_range(255, 0));
            send_word(wrd, 8, 1'b0, 1'b0, k < nw - 1, txs[(k + 1) % 4], cap);
            check($sformatf("rand_f%0d_w%0d_cipo", f, k), cap, txs[k]);
         end
         end_frame();
         check($sformatf("rand_f%0d_fc", f), frame_count, exp_fc);
         drain();
      end

      // Reset in the middle of a frame flushes everything.
      rx_ready = 1'b0;
      start_frame(1'b0, 1'b0, 1'b0, 8'h00);
      send_word(8'h11, 8, 1'b0, 1'b0, 1'b0, 8'h00, cap);
      send_word(8'h22, 8, 1'b0, 1'b0, 1'b0, 8'h00, cap);
      send_word(8'h33, 3, 1'b0, 1'b0, 1'b0, 8'h00, cap);
      rst = 1'b1;
      spi_cs_n = 1'b1;
      exp_q.delete();
      cycles(3);
      rst = 1'b0;
      cycles(1);
      check("mrst_valid", rx_valid, 0);
      check("mrst_data", rx_data, 0);
      check("mrst_fc", frame_count, 0);
      check("mrst_busy", busy, 0);
      start_frame(1'b0, 1'b0, 1'b0, 8'h00);
      send_word(8'h96, 8, 1'b0, 1'b0, 1'b0, 8'h00, cap);
      end_frame();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/spi_peripheral_rxfifo.md
SPI_PERIPHERAL_RXFIFO -- requirements
Module: spi_peripheral_rxfifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per SPI word (4..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, RX FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 10000, clk cycles without a sample edge mid-word before abort.
REQ-004 SHALL have parameter MSB_FIRST, default 1; 1 = MSB first on COPI/CIPO, 0 = LSB first.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 SCLK  input  1  asynchronous SPI clock.
REQ-008 COPI  input  1  asynchronous controller-out data.
REQ-009 spi_cs_n  input  1  asynchronous chip select, active low.
REQ-010 CIPO  output  1  peripheral-out data.
REQ-011 cpol, cpha  input  1 each  runtime SPI mode, latched at frame start.
REQ-012 rx_enable  input  1  permits frame start.
REQ-013 tx_data  input  DATA_W  next word for CIPO; tx_load  input  1  writes tx_data into TX holding register.
REQ-014 rx_data  output  DATA_W  FIFO head; rx_valid  output  1  FIFO non-empty; rx_ready  input  1  pop.
REQ-015 frame_count  output  16  words committed in current CS assertion.
REQ-016 overflow, timeout  output  1 each  sticky status; clr_status  input  1  clears both.
REQ-017 busy  output  1  state != IDLE.

Function
REQ-018 SCLK, COPI, spi_cs_n SHALL each pass a 2-FF synchronizer plus one edge-history FF; edges derived from stages 2/3.
REQ-019 Leading edge = idle->active per latched cpol; sample edge = leading if cpha=0, trailing if cpha=1; shift edge = the other.
REQ-020 States SHALL be IDLE, SHIFT, COMMIT, ABORT.
REQ-021 IDLE->SHIFT when synced CS low and rx_enable=1; same cycle latch cpol/cpha, bit_cnt=0, load TX shifter from holding register (holding register cleared to 0 after load).
REQ-022 With cpha=0, first CIPO bit SHALL be driven in the cycle after IDLE->SHIFT; subsequent bits advance on shift edges.
REQ-023 SHIFT: each sample edge shifts synced COPI in per MSB_FIRST and increments bit_cnt; on the DATA_W-th sample -> COMMIT.
REQ-024 COMMIT (one cycle): push word if FIFO not full, else drop word and set overflow; frame_count increments, saturating at 0xFFFF; next state SHIFT with bit_cnt=0 and TX shifter reloaded.
REQ-025 CS high in SHIFT SHALL go to IDLE, discard the partial word, no push, no count.
REQ-026 CS high in COMMIT SHALL still complete the push, then go to IDLE.
REQ-027 In SHIFT with bit_cnt>0 and no sample edge for TIMEOUT_CYCLES consecutive cycles -> ABORT, set timeout, discard partial word; idle gaps with bit_cnt=0 never time out.
REQ-028 ABORT ignores SCLK; -> IDLE once synced CS high.
REQ-029 frame_count SHALL clear on IDLE->SHIFT; holds value in IDLE.
REQ-030 FIFO SHALL be first-word-fall-through; rx_data = head when rx_valid, else 0; pop on rx_valid && rx_ready.
REQ-031 Latency: sample edge completing a word in cycle t -> COMMIT t+1 -> rx_valid=1 at t+2 (empty FIFO).
REQ-032 Push and pop same cycle when full SHALL be accepted, no overflow; when empty, pop ignored.
REQ-033 clr_status clears flags; a same-cycle setting event takes priority.
REQ-034 CIPO SHALL be 0 when CS high or state is IDLE/ABORT.

Reset
REQ-035 rst SHALL force IDLE, FIFO empty, rx_valid=0, rx_data=0, CIPO=0, frame_count=0, overflow=0, timeout=0, busy=0, TX holding=0, CS sync stages=1, SCLK/COPI stages=0.
REQ-036 rst mid-frame SHALL discard the partial word and all FIFO contents; frame restarts only after new CS falling.

Verification
REQ-037 Mode 0, DATA_W=8, MSB_FIRST=1: send 0xA5 -> rx_valid at t+2, rx_data=0xA5, frame_count=1.
REQ-038 Modes 1/2/3, each sending 0x3C with tx_load 0xC3 -> rx_data=0x3C and CIPO bits captured as 0xC3.
REQ-039 FIFO_DEPTH=4, rx_ready=0, 5 words -> first 4 retained in order, overflow=1; clr_status -> overflow=0.
REQ-040 CS high after 5 bits -> no push, frame_count unchanged, state IDLE.
REQ-041 Stall SCLK after 3 bits for TIMEOUT_CYCLES -> timeout=1, ABORT until CS high, no push.
REQ-042 Full FIFO, simultaneous pop and COMMIT -> count stays full, overflow=0.
